// File: rtl/tone_sweep_ctrl_pkg.sv
// Shared definitions for the tone sweep controller and its saturating adder.
//   state_t     : sequencer states (idle, running a sweep, one-cycle finish)
//   ATTEN_IDLE  : attenuation divisor that keeps sinegen silent; never 0
//   *_DEF       : default widths matching sinegen's phasein/attenuation ports
package tone_sweep_ctrl_pkg;

  localparam int PHW_DEF = 16;  // phase increment width
  localparam int ATW_DEF = 16;  // attenuation divisor width
  localparam int DWW_DEF = 16;  // dwell (samples per step) width
  localparam int NSW_DEF = 8;   // step count / step index width

  localparam logic [15:0] ATTEN_IDLE = 16'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/tone_sweep_ctrl_sat_add.sv
// sat_add_s16: combinational unsigned + signed saturating adder.
//   a : unsigned operand (current phase increment)
//   b : two's-complement operand (per-step delta)
//   y : a+b clamped to [0, 2^W-1]
module sat_add_s16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  // Two extra bits: one for the sign, one so that (2^W-1) + (2^(W-1)-1)
  // cannot wrap back into the positive range.
  logic [W+1:0] sum;

  always_comb begin
    sum = {2'b00, a} + {{2{b[W-1]}}, b};
    if (sum[W+1]) begin
      y = '0;                 // negative result
    end else if (sum[W]) begin
      y = '1;                 // above full scale
    end else begin
      y = sum[W-1:0];
    end
  end

endmodule

// File: rtl/tone_sweep_ctrl.sv
// tone_sweep_ctrl: sequences sinegen through a stepped-frequency sweep.
//   clock, resetn      : system clock, asynchronous active-low reset
//   start              : 1-cycle request; latches cfg_* and begins a sweep
//   abort              : ends a running sweep at once, without done
//   sample_tick        : 1-cycle strobe per audio sample
//   cfg_phase_start    : first phase increment (unsigned)
//   cfg_phase_step     : signed delta added per step (saturating)
//   cfg_nsteps         : number of frequency steps (0 behaves as 1)
//   cfg_dwell          : samples held per step (0 behaves as 1)
//   cfg_atten          : attenuation divisor during the sweep (0 -> idle value)
//   phasein            : to sinegen.phasein
//   attenuation        : to sinegen.attenuation, never 0
//   tone_en, busy      : tone active / sweep in progress
//   done               : 1-cycle pulse on normal completion
//   step_idx           : current 0-based step
module tone_sweep_ctrl
  import tone_sweep_ctrl_pkg::*;
#(
  parameter int PHW = PHW_DEF,
  parameter int ATW = ATW_DEF,
  parameter int DWW = DWW_DEF,
  parameter int NSW = NSW_DEF
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           start,
  input  logic           abort,
  input  logic           sample_tick,
  input  logic [PHW-1:0] cfg_phase_start,
  input  logic [PHW-1:0] cfg_phase_step,
  input  logic [NSW-1:0] cfg_nsteps,
  input  logic [DWW-1:0] cfg_dwell,
  input  logic [ATW-1:0] cfg_atten,
  output logic [PHW-1:0] phasein,
  output logic [ATW-1:0] attenuation,
  output logic           tone_en,
  output logic           busy,
  output logic           done,
  output logic [NSW-1:0] step_idx
);

  localparam logic [ATW-1:0] ATTEN_OFF = ATW'(ATTEN_IDLE);

  state_t         state;
  logic [PHW-1:0] step_reg;     // latched signed delta
  logic [NSW-1:0] nsteps_reg;   // latched step count, already forced >= 1
  logic [DWW-1:0] dwell_reg;    // latched dwell, already forced >= 1
  logic [DWW-1:0] dwell_cnt;
  logic [PHW-1:0] phase_next;
  logic           last_sample;
  logic           last_step;

  sat_add_s16 #(.W(PHW)) u_sat_add (
    .a (phasein),
    .b (step_reg),
    .y (phase_next)
  );

  assign last_sample = (dwell_cnt == dwell_reg - DWW'(1));
  assign last_step   = (step_idx == nsteps_reg - NSW'(1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      phasein     <= '0;
      attenuation <= ATTEN_OFF;
      tone_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_idx    <= '0;
      dwell_cnt   <= '0;
      step_reg    <= '0;
      nsteps_reg  <= '0;
      dwell_reg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          // abort beats a simultaneous start; a tick in the start cycle is not counted
          if (start && !abort) begin
            state       <= ST_RUN;
            busy        <= 1'b1;
            tone_en     <= 1'b1;
            phasein     <= cfg_phase_start;
            attenuation <= (cfg_atten == '0) ? ATTEN_OFF : cfg_atten;
            step_reg    <= cfg_phase_step;
            nsteps_reg  <= (cfg_nsteps == '0) ? NSW'(1) : cfg_nsteps;
            dwell_reg   <= (cfg_dwell == '0) ? DWW'(1) : cfg_dwell;
            step_idx    <= '0;
            dwell_cnt   <= '0;
          end
        end

        ST_RUN: begin
          if (abort) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            tone_en     <= 1'b0;
            phasein     <= '0;
            attenuation <= ATTEN_OFF;
            step_idx    <= '0;
            dwell_cnt   <= '0;
          end else if (sample_tick) begin
            if (!last_sample) begin
              dwell_cnt <= dwell_cnt + DWW'(1);
            end else if (last_step) begin
              state       <= ST_FIN;
              done        <= 1'b1;
              busy        <= 1'b0;
              tone_en     <= 1'b0;
              phasein     <= '0;
              attenuation <= ATTEN_OFF;
              step_idx    <= '0;
              dwell_cnt   <= '0;
            end else begin
              step_idx  <= step_idx + NSW'(1);
              dwell_cnt <= '0;
              phasein   <= phase_next;
            end
          end
        end

        ST_FIN: begin
          // start and abort are both ignored here; FIN always lasts one cycle
          state <= ST_IDLE;
          done  <= 1'b0;
        end

        default: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          tone_en     <= 1'b0;
          done        <= 1'b0;
          phasein     <= '0;
          attenuation <= ATTEN_OFF;
          step_idx    <= '0;
          dwell_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sweep_ctrl.sv
// Bench for tone_sweep_ctrl: directed scenarios followed by randomized sweeps,
// every cycle compared against a tick-counting reference model.
module tb_tone_sweep_ctrl;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        abort;
  logic        sample_tick;
  logic [15:0] cfg_phase_start;
  logic [15:0] cfg_phase_step;
  logic [7:0]  cfg_nsteps;
  logic [15:0] cfg_dwell;
  logic [15:0] cfg_atten;
  logic [15:0] phasein;
  logic [15:0] attenuation;
  logic        tone_en;
  logic        busy;
  logic        done;
  logic [7:0]  step_idx;

  int checks_total  = 0;
  int checks_passed = 0;

  tone_sweep_ctrl dut (
    .clock           (clock),
    .resetn          (resetn),
    .start           (start),
    .abort           (abort),
    .sample_tick     (sample_tick),
    .cfg_phase_start (cfg_phase_start),
    .cfg_phase_step  (cfg_phase_step),
    .cfg_nsteps      (cfg_nsteps),
    .cfg_dwell       (cfg_dwell),
    .cfg_atten       (cfg_atten),
    .phasein         (phasein),
    .attenuation     (attenuation),
    .tone_en         (tone_en),
    .busy            (busy),
    .done            (done),
    .step_idx        (step_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // A sweep is described only by how many ticks have been consumed;
  // the step is ticks/dwell and the phase comes from a precomputed list.
  bit m_active;
  bit m_fin;
  int m_ticks;
  int m_nsteps;
  int m_dwell;
  int m_atten;
  int m_phase[256];

  function automatic int sat_ref(input int p, input int s);
    int r;
    r = p + s;
    if (r < 0) return 0;
    if (r > 65535) return 65535;
    return r;
  endfunction

  function automatic void model_reset();
    m_active = 0;
    m_fin    = 0;
    m_ticks  = 0;
  endfunction

  function automatic void model_edge(input logic st, input logic ab, input logic tk);
    int s;
    if (m_fin) begin
      m_fin = 0;
    end else if (!m_active) begin
      if (st && !ab) begin
        m_active = 1;
        m_ticks  = 0;
        m_nsteps = (cfg_nsteps == 0) ? 1 : int'(cfg_nsteps);
        m_dwell  = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
        m_atten  = (cfg_atten == 0) ? 32'h7FFF : int'(cfg_atten);
        s = int'($signed(cfg_phase_step));
        m_phase[0] = int'(cfg_phase_start);
        for (int k = 1; k < m_nsteps; k++) m_phase[k] = sat_ref(m_phase[k-1], s);
      end
    end else if (ab) begin
      m_active = 0;
    end else if (tk) begin
      m_ticks++;
      if (m_ticks == m_nsteps * m_dwell) begin
        m_active = 0;
        m_fin    = 1;
      end
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs(input string tag);
    int k;
    k = m_active ? (m_ticks / m_dwell) : 0;
    chk({tag, ".phasein"},  32'(phasein),     m_active ? m_phase[k] : 0);
    chk({tag, ".atten"},    32'(attenuation), m_active ? m_atten : 32'h7FFF);
    chk({tag, ".tone_en"},  32'(tone_en),     32'(m_active));
    chk({tag, ".busy"},     32'(busy),        32'(m_active));
    chk({tag, ".done"},     32'(done),        32'(m_fin));
    chk({tag, ".step_idx"}, 32'(step_idx),    k);
  endtask

  // One clock: inputs driven at negedge, model advanced at posedge,
  // outputs sampled 1 time unit later.
  task automatic cyc(input string tag, input logic st, input logic ab, input logic tk);
    @(negedge clock);
    start = st; abort = ab; sample_tick = tk;
    @(posedge clock);
    model_edge(st, ab, tk);
    #1;
    start = 1'b0; abort = 1'b0; sample_tick = 1'b0;
    check_outputs(tag);
  endtask

  task automatic set_cfg(input logic [15:0] ps, input logic [15:0] pstep,
                         input logic [7:0] ns, input logic [15:0] dw, input logic [15:0] at);
    cfg_phase_start = ps; cfg_phase_step = pstep; cfg_nsteps = ns;
    cfg_dwell = dw; cfg_atten = at;
  endtask

  // Tick every cycle until the model says the sweep and its FIN are over.
  task automatic run_out(input string tag);
    int guard;
    guard = 0;
    while ((m_active || m_fin) && guard < 2000) begin
      cyc(tag, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk({tag, ".ended"}, 32'(busy), 0);
  endtask

  int done_cnt;
  int guard;
  logic st, ab, tk;

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; sample_tick = 1'b0;
    set_cfg(16'h0, 16'h0, 8'h0, 16'h0, 16'h0);
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    cyc("reset", 1'b0, 1'b0, 1'b0);

    // basic sweep, one tick every 4 clocks
    set_cfg(16'h0400, 16'h0100, 8'd3, 16'd2, 16'd4);
    cyc("t2", 1'b1, 1'b0, 1'b0);
    done_cnt = 0;
    for (int t = 0; t < 6; t++) begin
      for (int g = 0; g < 3; g++) begin
        cyc("t2", 1'b0, 1'b0, 1'b0);
        if (done) done_cnt++;
      end
      cyc("t2", 1'b0, 1'b0, 1'b1);
      if (done) done_cnt++;
    end
    for (int g = 0; g < 3; g++) begin
      cyc("t2", 1'b0, 1'b0, 1'b0);
      if (done) done_cnt++;
    end
    chk("t2.done_count", 32'(done_cnt), 1);
    $display("t2 basic sweep: 0x0400 +0x0100 x3 dwell 2");

    // saturation both directions
    set_cfg(16'hFF00, 16'h0080, 8'd4, 16'd1, 16'd9);
    cyc("t3a", 1'b1, 1'b0, 1'b0);
    run_out("t3a");
    set_cfg(16'h0100, 16'hFF00, 8'd3, 16'd1, 16'd9);
    cyc("t3b", 1'b1, 1'b0, 1'b0);
    run_out("t3b");
    $display("t3 saturation sweeps up and down");

    // zero config behaves as one step of one tick, idle attenuation
    set_cfg(16'h1234, 16'h0010, 8'd0, 16'd0, 16'd0);
    cyc("t4", 1'b1, 1'b0, 1'b1);      // tick with start is not counted
    cyc("t4", 1'b0, 1'b0, 1'b0);
    run_out("t4");
    $display("t4 zero config sweep");

    // abort with tick mid-run, then start during run and cfg change mid-run
    set_cfg(16'h0800, 16'h0040, 8'd5, 16'd3, 16'd7);
    cyc("t5a", 1'b1, 1'b0, 1'b0);
    cyc("t5a", 1'b0, 1'b0, 1'b1);
    cyc("t5a", 1'b0, 1'b0, 1'b1);
    cyc("t5a", 1'b0, 1'b1, 1'b1);
    cyc("t5a", 1'b0, 1'b0, 1'b0);
    cyc("t5a", 1'b1, 1'b1, 1'b0);     // start+abort in idle: stays idle
    set_cfg(16'h0300, 16'h0020, 8'd2, 16'd2, 16'd5);
    cyc("t5b", 1'b1, 1'b0, 1'b0);
    set_cfg(16'hAAAA, 16'h5555, 8'd9, 16'd9, 16'd3);
    cyc("t5b", 1'b1, 1'b0, 1'b1);
    run_out("t5b");
    $display("t5 abort and start contention");

    // asynchronous reset mid-run, checked with no clock edge in between
    set_cfg(16'h2000, 16'h0100, 8'd4, 16'd2, 16'd6);
    cyc("t1", 1'b1, 1'b0, 1'b0);
    cyc("t1", 1'b0, 1'b0, 1'b1);
    cyc("t1", 1'b0, 1'b0, 1'b1);
    resetn = 1'b0;
    #2;
    model_reset();
    check_outputs("t1.async");
    @(negedge clock);
    resetn = 1'b1;
    cyc("t1", 1'b0, 1'b0, 1'b1);
    $display("t1 asynchronous reset mid-sweep");

    // randomized sweeps; cfg inputs keep changing to prove they are latched
    for (int n = 0; n < 40; n++) begin
      cfg_phase_start = 16'($urandom);
      cfg_phase_step  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h2000) - 16'h1000);
      cfg_nsteps      = 8'($urandom_range(0, 7));
      cfg_dwell       = 16'($urandom_range(0, 4));
      cfg_atten       = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      st = 1'b1;
      ab = ($urandom_range(0, 9) == 0);
      tk = ($urandom_range(0, 2) == 0);
      cyc("rand", st, ab, tk);
      guard = 0;
      while ((m_active || m_fin) && guard < 3000) begin
        cfg_phase_start = 16'($urandom);
        cfg_nsteps      = 8'($urandom);
        cfg_dwell       = 16'($urandom);
        st = ($urandom_range(0, 9) == 0);
        ab = ($urandom_range(0, 59) == 0);
        tk = ($urandom_range(0, 2) == 0);
        cyc("rand", st, ab, tk);
        guard++;
      end
      chk("rand.ended", 32'(busy), 0);
      cyc("rand.gap", 1'b0, 1'b0, $urandom_range(0, 1) == 0);
      $display("sweep %0d: cycles=%0d nsteps=%0d dwell=%0d", n, guard, m_nsteps, m_dwell);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
